// File: rtl/pe_result_writeback_if.sv
// Result/memory bus bundle for pe_result_writeback: PE-side valid/ready vector
// push and memory-side req/ack word write.
interface pe_result_writeback_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int VECTOR_WIDTH = 16,
   parameter int MEM_WIDTH    = 256,
   parameter int ADDR_WIDTH   = 32
);
   logic                               valid_in;
   logic                               ready_out;
   logic [VECTOR_WIDTH*DATA_WIDTH-1:0] result_i;
   logic                               mem_req_o;
   logic [ADDR_WIDTH-1:0]              mem_addr_o;
   logic [MEM_WIDTH-1:0]               mem_data_o;
   logic                               mem_ack_i;

   // master: the surrounding PE and memory; slave: the writeback block
   modport master (
      output valid_in, result_i, mem_ack_i,
      input  ready_out, mem_req_o, mem_addr_o, mem_data_o
   );

   modport slave (
      input  valid_in, result_i, mem_ack_i,
      output ready_out, mem_req_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/pe_result_writeback.sv
// Buffers PE result vectors in a small FIFO and writes each as BEATS memory words
// at an auto-incrementing address. Optional stall counter: PE_WB_STALL_CNT_EN.
module pe_result_writeback #(
   parameter int DATA_WIDTH   = 32,
   parameter int VECTOR_WIDTH = 16,
   parameter int MEM_WIDTH    = 256,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   pe_result_writeback_if.slave    bus,
   input  logic                    start_i,
   input  logic [ADDR_WIDTH-1:0]   base_addr_i,
   output logic                    busy_o,
   output logic [15:0]             vec_count_o,
   output logic [31:0]             stall_cnt_o
);

   localparam int VEC_BITS = VECTOR_WIDTH * DATA_WIDTH;
   localparam int BEATS    = VEC_BITS / MEM_WIDTH;
   localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);

   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
   localparam logic [PTR_W:0]        PTR_ONE   = (PTR_W + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(MEM_WIDTH / 8);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           vec_count_q, vec_count_d;

   logic [VEC_BITS-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
   logic                  fifo_empty, fifo_full;
   logic                  push, pop, start_accept;
   logic [BEATS-1:0][MEM_WIDTH-1:0] head_beats;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign bus.ready_out = !fifo_full;
   assign push          = bus.valid_in && !fifo_full;
   assign busy_o        = (state_q != S_IDLE) || !fifo_empty;
   assign start_accept  = start_i && !busy_o;
   assign vec_count_o   = vec_count_q;

   assign head_beats     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
   assign bus.mem_req_o  = (state_q == S_REQ);
   assign bus.mem_addr_o = (state_q == S_REQ) ? addr_q : '0;
   assign bus.mem_data_o = (state_q == S_REQ) ? head_beats[beat_q] : '0;

   // NOTE: storage array has no reset; only the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.result_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         addr_q      <= '0;
         vec_count_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         addr_q      <= addr_d;
         vec_count_q <= vec_count_d;
      end
   end

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      addr_d      = addr_q;
      vec_count_d = vec_count_q;
      pop         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               beat_d  = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.mem_ack_i) begin
               addr_d = addr_q + ADDR_STEP;
               if (beat_q == LAST_BEAT) begin
                  pop         = 1'b1;
                  vec_count_d = vec_count_q + 16'd1;
                  state_d     = S_IDLE;
               end else begin
                  beat_d = beat_q + BEAT_ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Only accepted while idle and empty, so it never races an ack.
      if (start_accept) begin
         addr_d      = base_addr_i;
         vec_count_d = '0;
      end
   end

`ifdef PE_WB_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (start_accept) begin
         stall_q <= '0;
      end else if (bus.mem_req_o && !bus.mem_ack_i && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pe_result_writeback.sv
// Directed self-checking bench for pe_result_writeback: writeback ordering,
// ack stalls, backpressure, ignored start, address wrap and async reset.
module tb_pe_result_writeback;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] base_addr_i = '0;
   logic        busy_o;
   logic [15:0] vec_count_o;
   logic [31:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;

   pe_result_writeback_if bus ();

   pe_result_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .busy_o      (busy_o),
      .vec_count_o (vec_count_o),
      .stall_cnt_o (stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Vector whose element e holds base+e.
   function automatic logic [511:0] vec_of(input logic [31:0] base);
      logic [511:0] v;
      for (int e = 0; e < 16; e++) v[e*32 +: 32] = base + 32'(e);
      return v;
   endfunction

   // Memory word b of vec_of(base): elements 8*b .. 8*b+7, lowest element in the low bits.
   function automatic logic [255:0] beat_of(input logic [31:0] base, input int b);
      logic [255:0] w;
      for (int e = 0; e < 8; e++) w[e*32 +: 32] = base + 32'(b*8 + e);
      return w;
   endfunction

   task automatic push_vec(input logic [31:0] base);
      bus.valid_in = 1'b1;
      bus.result_i = vec_of(base);
      step();
      bus.valid_in = 1'b0;
   endtask

   // Wait (bounded) for a request, check it, then accept it with a one-cycle ack.
   task automatic expect_write(input string tag, input logic [31:0] addr, input logic [255:0] data);
      int n = 0;
      while (!bus.mem_req_o && n < 20) begin
         step();
         n++;
      end
      check({tag, "_req"},  256'(bus.mem_req_o),  256'(1));
      check({tag, "_addr"}, 256'(bus.mem_addr_o), 256'(addr));
      check({tag, "_data"}, bus.mem_data_o,       data);
      bus.mem_ack_i = 1'b1;
      step();
   endtask

   initial begin
      bus.valid_in  = 1'b0;
      bus.result_i  = '0;
      bus.mem_ack_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 256'(bus.ready_out),  256'(1));
      check("rst_req",   256'(bus.mem_req_o),  256'(0));
      check("rst_addr",  256'(bus.mem_addr_o), 256'(0));
      check("rst_data",  bus.mem_data_o,       256'(0));
      check("rst_busy",  256'(busy_o),         256'(0));
      check("rst_vec",   256'(vec_count_o),    256'(0));
      check("rst_stall", 256'(stall_cnt_o),    256'(0));
      rst = 1'b0;
      step();

      // 1: single vector with ack tied high
      bus.mem_ack_i = 1'b1;
      start_i       = 1'b1;
      base_addr_i   = 32'h0000_1000;
      push_vec(32'h0);
      start_i = 1'b0;
      check("t1_lat_req",  256'(bus.mem_req_o), 256'(0));
      check("t1_lat_busy", 256'(busy_o),        256'(1));
      step();
      check("t1_req_up",  256'(bus.mem_req_o),        256'(1));
      check("t1_elem0",   256'(bus.mem_data_o[31:0]), 256'(0));
      check("t1_elem1",   256'(bus.mem_data_o[63:32]), 256'(1));
      expect_write("t1_b0", 32'h0000_1000, beat_of(32'h0, 0));
      check("t1_elem8", 256'(bus.mem_data_o[31:0]), 256'(8));
      expect_write("t1_b1", 32'h0000_1020, beat_of(32'h0, 1));
      check("t1_vec",  256'(vec_count_o),   256'(1));
      check("t1_busy", 256'(busy_o),        256'(0));
      check("t1_req",  256'(bus.mem_req_o), 256'(0));

      // 2: ack after 3 wait cycles per beat; continues at 0x1040
      bus.mem_ack_i = 1'b0;
      push_vec(32'h100);
      step();
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < 4; c++) begin
            check($sformatf("t2_b%0d_c%0d_req", b, c),  256'(bus.mem_req_o),  256'(1));
            check($sformatf("t2_b%0d_c%0d_addr", b, c), 256'(bus.mem_addr_o), 256'(32'h1040 + 32'(b*32)));
            check($sformatf("t2_b%0d_c%0d_data", b, c), bus.mem_data_o,       beat_of(32'h100, b));
            if (c == 3) bus.mem_ack_i = 1'b1;
            step();
            bus.mem_ack_i = 1'b0;
         end
      end
      check("t2_vec",  256'(vec_count_o), 256'(2));
      check("t2_busy", 256'(busy_o),      256'(0));
`ifdef PE_WB_STALL_CNT_EN
      check("t2_stall", 256'(stall_cnt_o), 256'(6));
`else
      check("t2_stall", 256'(stall_cnt_o), 256'(0));
`endif

      // 3: backpressure with ack held low
      for (int n = 0; n < 4; n++) begin
         check($sformatf("t3_ready_%0d", n), 256'(bus.ready_out), 256'(1));
         bus.valid_in = 1'b1;
         bus.result_i = vec_of(32'h200 + 32'(n*16));
         step();
      end
      bus.result_i = vec_of(32'h240);
      for (int n = 0; n < 3; n++) begin
         check($sformatf("t3_full_%0d", n), 256'(bus.ready_out), 256'(0));
         step();
      end
      bus.valid_in = 1'b0;
      expect_write("t3_v0_b0", 32'h0000_1080, beat_of(32'h200, 0));
      check("t3_still_full", 256'(bus.ready_out), 256'(0));
      expect_write("t3_v0_b1", 32'h0000_10A0, beat_of(32'h200, 1));
      check("t3_ready_back", 256'(bus.ready_out), 256'(1));
      for (int n = 1; n < 4; n++) begin
         for (int b = 0; b < 2; b++) begin
            expect_write($sformatf("t3_v%0d_b%0d", n, b), 32'h1080 + 32'(n*64 + b*32),
                         beat_of(32'h200 + 32'(n*16), b));
         end
      end
      check("t3_vec",  256'(vec_count_o),   256'(6));
      check("t3_busy", 256'(busy_o),        256'(0));
      check("t3_req",  256'(bus.mem_req_o), 256'(0));

      // 4: start while busy is ignored
      bus.mem_ack_i = 1'b0;
      push_vec(32'h300);
      check("t4_busy", 256'(busy_o), 256'(1));
      start_i     = 1'b1;
      base_addr_i = 32'h0000_2000;
      step();
      step();
      start_i = 1'b0;
      check("t4_addr_kept", 256'(bus.mem_addr_o), 256'(32'h1180));
      check("t4_vec_kept",  256'(vec_count_o),    256'(6));
      expect_write("t4_b0", 32'h0000_1180, beat_of(32'h300, 0));
      expect_write("t4_b1", 32'h0000_11A0, beat_of(32'h300, 1));
      check("t4_vec", 256'(vec_count_o), 256'(7));

      // 5: address wrap, start and push in the same cycle
      check("t5_idle", 256'(busy_o), 256'(0));
      start_i     = 1'b1;
      base_addr_i = 32'hFFFF_FFE0;
      push_vec(32'h400);
      start_i = 1'b0;
      expect_write("t5_b0", 32'hFFFF_FFE0, beat_of(32'h400, 0));
      expect_write("t5_b1", 32'h0000_0000, beat_of(32'h400, 1));
      check("t5_vec",   256'(vec_count_o), 256'(1));
      check("t5_stall", 256'(stall_cnt_o), 256'(0));

      // 6: asynchronous reset on beat 1
      bus.mem_ack_i = 1'b0;
      push_vec(32'h500);
      step();
      check("t6_b0_addr", 256'(bus.mem_addr_o), 256'(32'h20));
      bus.mem_ack_i = 1'b1;
      step();
      bus.mem_ack_i = 1'b0;
      check("t6_b1_req",  256'(bus.mem_req_o),  256'(1));
      check("t6_b1_addr", 256'(bus.mem_addr_o), 256'(32'h40));
      #2;
      rst = 1'b1;
      #1;
      check("t6_req",   256'(bus.mem_req_o),  256'(0));
      check("t6_ready", 256'(bus.ready_out),  256'(1));
      check("t6_vec",   256'(vec_count_o),    256'(0));
      check("t6_busy",  256'(busy_o),         256'(0));
      check("t6_addr",  256'(bus.mem_addr_o), 256'(0));
      step();
      rst = 1'b0;
      step();
      bus.mem_ack_i = 1'b1;
      push_vec(32'h600);
      expect_write("t6_new_b0", 32'h0000_0000, beat_of(32'h600, 0));
      expect_write("t6_new_b1", 32'h0000_0020, beat_of(32'h600, 1));
      check("t6_new_vec", 256'(vec_count_o), 256'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
